// File: rtl/conv3x3_sequencer_if.sv
// Control, buffer-read and result bundle of the 3x3 convolution sequencer.
// The master side is the sequencer. The slave side is the buffers, the datapath and the consumer.
interface conv3x3_sequencer_if #(
  parameter int X_BW    = 8,
  parameter int W_BW    = 8,
  parameter int PSUM_BW = 16,
  parameter int Y_BW    = 16,
  parameter int ADDR_BW = 4
) ();
  logic               i_start;
  logic               i_clear;
  logic [PSUM_BW-1:0] i_bias;
  logic               o_busy;
  logic               o_rd_en;
  logic [ADDR_BW-1:0] o_addr;
  logic [X_BW-1:0]    i_x_rdata;
  logic [W_BW-1:0]    i_w_rdata;
  logic [X_BW-1:0]    o_x;
  logic [W_BW-1:0]    o_w;
  logic               o_tap_vld;
  logic               o_first;
  logic [PSUM_BW-1:0] o_psum;
  logic [Y_BW-1:0]    i_dp_y;
  logic [Y_BW-1:0]    o_y;
  logic               o_y_vld;
  logic               i_y_ready;
  logic               o_done;

  modport master (
    input  i_start, i_clear, i_bias, i_x_rdata, i_w_rdata, i_dp_y, i_y_ready,
    output o_busy, o_rd_en, o_addr, o_x, o_w, o_tap_vld, o_first, o_psum,
           o_y, o_y_vld, o_done
  );

  modport slave (
    output i_start, i_clear, i_bias, i_x_rdata, i_w_rdata, i_dp_y, i_y_ready,
    input  o_busy, o_rd_en, o_addr, o_x, o_w, o_tap_vld, o_first, o_psum,
           o_y, o_y_vld, o_done
  );
endinterface

// File: rtl/conv3x3_sequencer.sv
// Sequences one 3x3 pass: it reads 9 taps, streams them to the PE chain, waits out the pipeline and holds the result.
// The tap stream cannot be stalled. The result is held until the consumer is ready, and i_clear aborts the pass.
module conv3x3_sequencer #(
  parameter int X_BW     = 8,
  parameter int W_BW     = 8,
  parameter int PSUM_BW  = 16,
  parameter int Y_BW     = 16,
  parameter int TAPS     = 9,
  parameter int PIPE_LAT = 5,
  parameter int ADDR_BW  = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  conv3x3_sequencer_if.master bus
);
  localparam int LAT_BW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, ALIGN, DRAIN, HOLD} state_t;

  state_t             state_q;
  logic [ADDR_BW-1:0] tap_cnt_q, tap_cnt_d;
  logic [LAT_BW-1:0]  lat_cnt_q, lat_cnt_d;
  logic               rd_en_q;
  logic               rdv_q, rdv_first_q;
  logic               tap_vld_q, first_q;
  logic [X_BW-1:0]    x_q;
  logic [W_BW-1:0]    w_q;
  logic [PSUM_BW-1:0] psum_q;
  logic [Y_BW-1:0]    y_q;
  logic               y_vld_q;

  assign tap_cnt_d = tap_cnt_q + 1'b1;
  assign lat_cnt_d = lat_cnt_q - 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
      lat_cnt_q <= '0;
      rd_en_q   <= 1'b0;
      psum_q    <= '0;
      y_q       <= '0;
      y_vld_q   <= 1'b0;
    end else if (bus.i_clear) begin
      state_q   <= IDLE;
      tap_cnt_q <= '0;
      lat_cnt_q <= '0;
      rd_en_q   <= 1'b0;
      y_vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            psum_q    <= bus.i_bias;
            tap_cnt_q <= '0;
            rd_en_q   <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (tap_cnt_q == ADDR_BW'(TAPS - 1)) begin
            rd_en_q   <= 1'b0;
            tap_cnt_q <= '0;
            state_q   <= ALIGN;
          end else begin
            tap_cnt_q <= tap_cnt_d;
          end
        end
        ALIGN: begin
          // The count also covers the cycle the last tap sits on o_x/o_w, so capture lands PIPE_LAT after it.
          lat_cnt_q <= LAT_BW'(PIPE_LAT);
          state_q   <= DRAIN;
        end
        DRAIN: begin
          if (lat_cnt_q == '0) begin
            y_q     <= bus.i_dp_y;
            y_vld_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            lat_cnt_q <= lat_cnt_d;
          end
        end
        HOLD: begin
          if (bus.i_y_ready) begin
            y_vld_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the strobe and is registered once more onto the tap bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdv_q       <= 1'b0;
      rdv_first_q <= 1'b0;
      tap_vld_q   <= 1'b0;
      first_q     <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
    end else if (bus.i_clear) begin
      rdv_q       <= 1'b0;
      rdv_first_q <= 1'b0;
      tap_vld_q   <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      rdv_q       <= rd_en_q;
      rdv_first_q <= rd_en_q && (tap_cnt_q == '0);
      tap_vld_q   <= rdv_q;
      first_q     <= rdv_first_q;
      if (rdv_q) begin
        x_q <= bus.i_x_rdata;
        w_q <= bus.i_w_rdata;
      end
    end
  end

  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_rd_en   = rd_en_q;
  assign bus.o_addr    = tap_cnt_q;
  assign bus.o_x       = x_q;
  assign bus.o_w       = w_q;
  assign bus.o_tap_vld = tap_vld_q;
  assign bus.o_first   = first_q;
  assign bus.o_psum    = psum_q;
  assign bus.o_y       = y_q;
  assign bus.o_y_vld   = y_vld_q;
  assign bus.o_done    = y_vld_q & bus.i_y_ready & ~bus.i_clear;
endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Directed bench for conv3x3_sequencer: table of passes plus reset, clear and start-while-busy sequences.
module tb_conv3x3_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv3x3_sequencer_if #(.X_BW(8), .W_BW(8), .PSUM_BW(16), .Y_BW(16), .ADDR_BW(4)) bus ();

  conv3x3_sequencer #(
    .X_BW(8), .W_BW(8), .PSUM_BW(16), .Y_BW(16), .TAPS(9), .PIPE_LAT(5), .ADDR_BW(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Single-port buffers with registered read data and a junk value when not read.
  logic [7:0] x_mem [16];
  logic [7:0] w_mem [16];
  always @(posedge clk) begin
    if (bus.o_rd_en) begin
      bus.i_x_rdata <= x_mem[bus.o_addr];
      bus.i_w_rdata <= w_mem[bus.o_addr];
    end else begin
      bus.i_x_rdata <= 8'hA5;
      bus.i_w_rdata <= 8'h5A;
    end
  end

  typedef struct packed {
    logic [8:0][7:0] x;
    logic [8:0][7:0] w;
    logic [15:0]     bias;
    logic [15:0]     dp_y;
    logic [7:0]      wait_n;
    logic            pulse;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input vec_t v);
    for (int k = 0; k < 9; k++) begin
      x_mem[k] = v.x[k];
      w_mem[k] = v.w[k];
    end
  endtask

  task automatic start_pass(input logic [15:0] bias);
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_bias  = bias;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_bias  = 16'h7777;
  endtask

  task automatic do_pass(input vec_t v, input int id);
    int rd_cnt = 0, rd_ok = 0, tp_cnt = 0, tp_ok = 0, first_cnt = 0;
    int psum_bad = 0, y_bad = 0, vld_r = -1, done_r = -1, done_cnt = 0, busy_after = 0;
    logic accepted = 1'b0;
    logic [15:0] y_at_done = 16'h0;
    logic [7:0]  x_at_done = 8'h0;
    load_mem(v);
    start_pass(v.bias);
    for (int r = 1; r <= 80; r++) begin
      if (r > 1) begin
        @(posedge clk); #1;
      end
      bus.i_dp_y    = (r == 16) ? v.dp_y : (v.dp_y ^ (r[0] ? 16'h5A5A : 16'hA5A5));
      bus.i_y_ready = (r >= 17 + int'(v.wait_n));
      bus.i_start   = v.pulse && (r == 4 || r == 18);
      @(negedge clk);
      if (r == 1) accepted = bus.o_busy && bus.o_rd_en && (bus.o_addr == 4'd0);
      if (bus.o_rd_en) begin
        rd_cnt++;
        if (bus.o_addr == 4'(r - 1)) rd_ok++;
      end
      if (bus.o_tap_vld) begin
        tp_cnt++;
        if (r >= 3 && r <= 11 && bus.o_x == v.x[r-3] && bus.o_w == v.w[r-3] &&
            bus.o_first == (r == 3))
          tp_ok++;
      end
      if (bus.o_first) first_cnt++;
      if (bus.o_busy && bus.o_psum != v.bias) psum_bad++;
      if (bus.o_y_vld) begin
        if (vld_r < 0) vld_r = r;
        if (bus.o_y != v.dp_y) y_bad++;
      end
      if (bus.o_done) begin
        done_cnt++;
        done_r    = r;
        y_at_done = bus.o_y;
        x_at_done = bus.o_x;
        break;
      end
    end
    bus.i_start = 1'b0;
    if (v.pulse) begin
      repeat (3) begin
        @(negedge clk);
        if (bus.o_done) done_cnt++;
        if (bus.o_busy) busy_after++;
      end
      check($sformatf("p%0d idle after done", id), busy_after, 0);
    end
    check($sformatf("p%0d start accepted", id), accepted, 1);
    check($sformatf("p%0d read count", id), rd_cnt, 9);
    check($sformatf("p%0d read addr seq", id), rd_ok, 9);
    check($sformatf("p%0d tap count", id), tp_cnt, 9);
    check($sformatf("p%0d tap data/first", id), tp_ok, 9);
    check($sformatf("p%0d first count", id), first_cnt, 1);
    check($sformatf("p%0d psum held", id), psum_bad, 0);
    check($sformatf("p%0d y_vld cycle", id), vld_r, 17);
    check($sformatf("p%0d done cycle", id), done_r, 17 + int'(v.wait_n));
    check($sformatf("p%0d done count", id), done_cnt, 1);
    check($sformatf("p%0d y stable", id), y_bad, 0);
    check($sformatf("p%0d y at done", id), y_at_done, v.dp_y);
    check($sformatf("p%0d x hold", id), x_at_done, v.x[8]);
  endtask

  function automatic logic [63:0] all_outs();
    return {6'd0, bus.o_busy, bus.o_rd_en, bus.o_addr, bus.o_x, bus.o_w, bus.o_tap_vld,
            bus.o_first, bus.o_psum, bus.o_y, bus.o_y_vld, bus.o_done};
  endfunction

  vec_t tbl [4];

  initial begin
    logic vld_seen, done_seen;
    // x=1..9, w=1, bias 10 -> 45+10
    for (int k = 0; k < 9; k++) begin
      tbl[0].x[k] = 8'(k + 1);
      tbl[0].w[k] = 8'd1;
    end
    tbl[0].bias = 16'd10; tbl[0].dp_y = 16'd55; tbl[0].wait_n = 8'd0; tbl[0].pulse = 1'b0;
    // 127 * -128 * 9 saturates to -32768
    for (int k = 0; k < 9; k++) begin
      tbl[1].x[k] = 8'd127;
      tbl[1].w[k] = 8'h80;
    end
    tbl[1].bias = 16'd0; tbl[1].dp_y = 16'h8000; tbl[1].wait_n = 8'd0; tbl[1].pulse = 1'b0;
    // x=-4..4, w=2 -> 0, bias -100; 20 cycles of back-pressure
    for (int k = 0; k < 9; k++) begin
      tbl[2].x[k] = 8'(k - 4);
      tbl[2].w[k] = 8'd2;
    end
    tbl[2].bias = 16'hFF9C; tbl[2].dp_y = 16'hFF9C; tbl[2].wait_n = 8'd20; tbl[2].pulse = 1'b0;
    // x=10..18, w=-1 -> -126, bias 200 -> 74; start pulsed in FETCH and HOLD
    for (int k = 0; k < 9; k++) begin
      tbl[3].x[k] = 8'(k + 10);
      tbl[3].w[k] = 8'hFF;
    end
    tbl[3].bias = 16'd200; tbl[3].dp_y = 16'd74; tbl[3].wait_n = 8'd5; tbl[3].pulse = 1'b1;

    bus.i_start = 1'b0; bus.i_clear = 1'b0; bus.i_bias = 16'h0;
    bus.i_dp_y = 16'h0; bus.i_y_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", all_outs(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", {bus.o_busy, bus.o_rd_en}, 2'b00);

    // Reset while tap 4 is on the bus
    load_mem(tbl[0]);
    start_pass(16'd33);
    for (int r = 1; r <= 7; r++) begin
      if (r > 1) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
    end
    check("tap4 before reset", {bus.o_tap_vld, bus.o_x}, {1'b1, 8'd5});
    rst_n = 1'b0;
    #1;
    check("async reset outputs", all_outs(), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after mid-pass reset", {bus.o_busy, bus.o_rd_en, bus.o_tap_vld}, 3'b000);

    // Clear during DRAIN
    vld_seen = 1'b0; done_seen = 1'b0;
    start_pass(16'h0123);
    for (int r = 1; r <= 30; r++) begin
      if (r > 1) begin
        @(posedge clk); #1;
      end
      bus.i_clear   = (r == 13);
      bus.i_y_ready = 1'b1;
      bus.i_dp_y    = 16'(r * 16'h0101);
      @(negedge clk);
      if (r == 12) check("drain before clear", bus.o_busy, 1);
      if (r == 14) begin
        check("busy after clear", bus.o_busy, 0);
        check("flags after clear", {bus.o_rd_en, bus.o_tap_vld, bus.o_y_vld}, 3'b000);
        check("psum kept on clear", bus.o_psum, 16'h0123);
      end
      vld_seen  |= bus.o_y_vld;
      done_seen |= bus.o_done;
    end
    bus.i_clear = 1'b0;
    check("no y_vld after clear", vld_seen, 0);
    check("no done after clear", done_seen, 0);

    for (int i = 0; i < 4; i++) do_pass(tbl[i], i);
    do_pass(tbl[0], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
